// File: rtl/ring_nic.sv
// ring_nic: network interface between a processor core and the PE port of a
// ring router. Exposes one receive buffer and one transmit buffer through a
// 4-entry register map; transmit is gated by the ring's VC phase (polarity).
module ring_nic #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             polarity,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    input  logic             nicEn,
    input  logic             nicWrEn,
    output logic             net_so,
    input  logic             net_ro,
    output logic [WIDTH-1:0] net_do,
    input  logic             net_si,
    output logic             net_ri,
    input  logic [WIDTH-1:0] net_di
);

    localparam int unsigned VC_BIT       = WIDTH - 1;
    localparam logic [1:0]  ADDR_IN_BUF  = 2'd0;
    localparam logic [1:0]  ADDR_IN_STS  = 2'd1;
    localparam logic [1:0]  ADDR_OUT_BUF = 2'd2;
    localparam logic [1:0]  ADDR_OUT_STS = 2'd3;

    logic [WIDTH-1:0] r_in_buf;
    logic             r_in_full;
    logic [WIDTH-1:0] r_out_buf;
    logic             r_out_full;
    logic [WIDTH-1:0] r_d_out;

    logic             w_rd;
    logic             w_wr;
    logic             w_in_push;
    logic             w_in_pop;
    logic             w_out_load;
    logic             w_out_send;
    logic             w_vc_match;
    logic [WIDTH-1:0] w_rd_data;

    // Decode processor access and both network handshakes from pre-edge state.
    always_comb begin
        w_rd       = nicEn & ~nicWrEn;
        w_wr       = nicEn & nicWrEn;
        w_vc_match = (r_out_buf[VC_BIT] == polarity);
        w_in_push  = net_si & ~r_in_full;
        w_in_pop   = w_rd & (addr == ADDR_IN_BUF) & r_in_full;
        // A write to a full transmit buffer is dropped even if the buffer
        // drains on the same edge.
        w_out_load = w_wr & (addr == ADDR_OUT_BUF) & ~r_out_full;
        w_out_send = r_out_full & w_vc_match & net_ro;
    end

    // Read-data mux for the register map.
    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_IN_BUF:  w_rd_data = r_in_buf;
            ADDR_IN_STS:  w_rd_data = WIDTH'(r_in_full);
            ADDR_OUT_BUF: w_rd_data = r_out_buf;
            ADDR_OUT_STS: w_rd_data = WIDTH'(r_out_full);
            default:      w_rd_data = '0;
        endcase
    end

    // Receive channel: capture from the router when empty, drain on addr0 read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_buf  <= '0;
            r_in_full <= 1'b0;
        end else begin
            if (w_in_push) begin
                r_in_buf  <= net_di;
                r_in_full <= 1'b1;
            end else if (w_in_pop) begin
                r_in_full <= 1'b0;
            end
        end
    end

    // Transmit channel: load from the processor, clear full on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_buf  <= '0;
            r_out_full <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_out_buf  <= d_in;
                r_out_full <= 1'b1;
            end else if (w_out_send) begin
                r_out_full <= 1'b0;
            end
        end
    end

    // Registered processor read data; holds when not reading.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d_out <= '0;
        end else if (w_rd) begin
            r_d_out <= w_rd_data;
        end
    end

    // Outputs: handshake signals are combinational from state and polarity.
    always_comb begin
        d_out  = r_d_out;
        net_do = r_out_buf;
        net_so = r_out_full & w_vc_match;
        net_ri = ~r_in_full;
    end

endmodule

// File: tb/tb_ring_nic.sv
// Directed bench for ring_nic: a vector table for the steady-state behaviour
// plus hand-written sequences for same-edge drop and asynchronous reset.
module tb_ring_nic;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             polarity;
    logic [1:0]       addr;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             nicEn;
    logic             nicWrEn;
    logic             net_so;
    logic             net_ro;
    logic [WIDTH-1:0] net_do;
    logic             net_si;
    logic             net_ri;
    logic [WIDTH-1:0] net_di;

    int n_cmp;
    int n_bad;

    ring_nic #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .addr(addr),
        .d_in(d_in), .d_out(d_out), .nicEn(nicEn), .nicWrEn(nicWrEn),
        .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: inputs, pre-edge handshake expectations, and
    // the d_out value expected after the edge.
    typedef struct {
        logic             pol;
        logic             en;
        logic             wr;
        logic [1:0]       a;
        logic [WIDTH-1:0] din;
        logic             si;
        logic [WIDTH-1:0] di;
        logic             ro;
        logic             exp_so;
        logic             exp_ri;
        logic [WIDTH-1:0] exp_do;
        logic [WIDTH-1:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic pol, logic en, logic wr, logic [1:0] a,
                                logic [WIDTH-1:0] din, logic si,
                                logic [WIDTH-1:0] di, logic ro, logic exp_so,
                                logic exp_ri, logic [WIDTH-1:0] exp_do,
                                logic [WIDTH-1:0] exp_dout);
        vec_t v;
        v.pol = pol; v.en = en; v.wr = wr; v.a = a; v.din = din;
        v.si = si; v.di = di; v.ro = ro; v.exp_so = exp_so;
        v.exp_ri = exp_ri; v.exp_do = exp_do; v.exp_dout = exp_dout;
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pol, input logic en, input logic wr,
                         input logic [1:0] a, input logic [WIDTH-1:0] din,
                         input logic si, input logic [WIDTH-1:0] di,
                         input logic ro);
        polarity = pol; nicEn = en; nicWrEn = wr; addr = a; d_in = din;
        net_si = si; net_di = di; net_ro = ro;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [WIDTH-1:0] PKT_AA = 64'h8000_0000_0000_00AA;
    localparam logic [WIDTH-1:0] Z      = '0;
    localparam logic [WIDTH-1:0] ONE    = 64'd1;

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        n_cmp = 0;
        n_bad = 0;

        // Reset held with traffic and writes active.
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 2'd2, 64'hDEAD, 1'b1, 64'h5555, 1'b1);
        repeat (3) edge_step();
        check("rst_so", WIDTH'(net_so), Z);
        check("rst_ri", WIDTH'(net_ri), ONE);
        check("rst_dout", d_out, Z);
        #2;
        reset = 1'b1;

        //          pol  en  wr  a  din                    si  di      ro  so  ri  do      dout
        vecs.push_back(mk(0, 1, 0, 1, Z,                    0, Z,       0,  0,  1, Z,      Z));
        vecs.push_back(mk(1, 1, 0, 3, Z,                    0, Z,       0,  0,  1, Z,      Z));
        vecs.push_back(mk(0, 1, 1, 2, PKT_AA,               0, Z,       0,  0,  1, Z,      Z));
        vecs.push_back(mk(1, 0, 0, 0, Z,                    0, Z,       0,  1,  1, PKT_AA, Z));
        vecs.push_back(mk(0, 1, 1, 2, 64'h1234,             0, Z,       0,  0,  1, PKT_AA, Z));
        vecs.push_back(mk(1, 1, 0, 3, Z,                    0, Z,       0,  1,  1, PKT_AA, ONE));
        vecs.push_back(mk(0, 1, 0, 2, Z,                    0, Z,       1,  0,  1, PKT_AA, PKT_AA));
        vecs.push_back(mk(1, 0, 0, 0, Z,                    0, Z,       1,  1,  1, PKT_AA, PKT_AA));
        vecs.push_back(mk(0, 1, 0, 3, Z,                    0, Z,       0,  0,  1, PKT_AA, Z));
        vecs.push_back(mk(1, 0, 0, 0, Z,                    1, 64'hBEEF,0,  0,  1, PKT_AA, Z));
        vecs.push_back(mk(0, 1, 0, 1, Z,                    1, 64'hCAFE,0,  0,  0, PKT_AA, ONE));
        vecs.push_back(mk(1, 1, 0, 0, Z,                    1, 64'hCAFE,0,  0,  0, PKT_AA, 64'hBEEF));
        vecs.push_back(mk(0, 0, 0, 0, Z,                    1, 64'hCAFE,0,  0,  1, PKT_AA, 64'hBEEF));
        vecs.push_back(mk(1, 1, 0, 0, Z,                    0, Z,       0,  0,  0, PKT_AA, 64'hCAFE));
        vecs.push_back(mk(0, 1, 0, 0, Z,                    0, Z,       0,  0,  1, PKT_AA, 64'hCAFE));
        vecs.push_back(mk(1, 1, 1, 2, 64'h55,               1, 64'h77,  0,  0,  1, PKT_AA, 64'hCAFE));
        vecs.push_back(mk(0, 1, 0, 3, Z,                    0, Z,       0,  1,  0, 64'h55, ONE));
        vecs.push_back(mk(1, 1, 0, 1, Z,                    0, Z,       0,  0,  0, 64'h55, ONE));
        vecs.push_back(mk(0, 1, 1, 0, 64'hFFFF,             0, Z,       0,  1,  0, 64'h55, ONE));
        vecs.push_back(mk(1, 1, 0, 0, Z,                    0, Z,       0,  0,  0, 64'h55, 64'h77));
        vecs.push_back(mk(0, 0, 0, 0, Z,                    1, 64'h99,  0,  1,  1, 64'h55, 64'h77));

        foreach (vecs[i]) begin
            drive(vecs[i].pol, vecs[i].en, vecs[i].wr, vecs[i].a, vecs[i].din,
                  vecs[i].si, vecs[i].di, vecs[i].ro);
            #1;
            check($sformatf("v%0d_so", i), WIDTH'(net_so), WIDTH'(vecs[i].exp_so));
            check($sformatf("v%0d_ri", i), WIDTH'(net_ri), WIDTH'(vecs[i].exp_ri));
            check($sformatf("v%0d_do", i), net_do, vecs[i].exp_do);
            edge_step();
            check($sformatf("v%0d_dout", i), d_out, vecs[i].exp_dout);
        end

        // Write to addr2 on the edge the send completes is dropped.
        drive(1'b1, 1'b0, 1'b0, 2'd0, Z, 1'b0, Z, 1'b0);
        edge_step();
        drive(1'b0, 1'b1, 1'b1, 2'd2, 64'hDD, 1'b0, Z, 1'b1);
        #1;
        check("drop_so", WIDTH'(net_so), ONE);
        edge_step();
        drive(1'b1, 1'b1, 1'b0, 2'd2, Z, 1'b0, Z, 1'b0);
        #1;
        check("drop_so_after", WIDTH'(net_so), Z);
        edge_step();
        check("drop_buf", d_out, 64'h55);
        drive(1'b0, 1'b1, 1'b0, 2'd3, Z, 1'b0, Z, 1'b0);
        edge_step();
        check("drop_full", d_out, Z);

        // Asynchronous reset with both channels full.
        drive(1'b1, 1'b1, 1'b1, 2'd2, 64'h8000_0000_0000_0001, 1'b0, Z, 1'b0);
        edge_step();
        drive(1'b0, 1'b0, 1'b0, 2'd0, Z, 1'b0, Z, 1'b0);
        edge_step();
        drive(1'b1, 1'b0, 1'b0, 2'd0, Z, 1'b0, Z, 1'b0);
        #1;
        check("pre_arst_so", WIDTH'(net_so), ONE);
        check("pre_arst_ri", WIDTH'(net_ri), Z);
        reset = 1'b0;
        #1;
        check("arst_so", WIDTH'(net_so), Z);
        check("arst_ri", WIDTH'(net_ri), ONE);
        check("arst_dout", d_out, Z);
        edge_step();
        #2;
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 2'd0, Z, 1'b0, Z, 1'b0);
        edge_step();
        check("arst_rd_in", d_out, Z);
        drive(1'b1, 1'b1, 1'b0, 2'd3, Z, 1'b0, Z, 1'b0);
        edge_step();
        check("arst_rd_ofull", d_out, Z);
        check("arst_so_after", WIDTH'(net_so), Z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ring_nic.md
Name: ring_nic

Overview:
- Network interface controller between a processor core and the PE port of one ring router.
- Processor side: a 4-entry memory-mapped register interface, exposing one input-channel buffer and one output-channel buffer.
- Network side: the send/ready/data handshake of the router PE port, in both directions.
  - Drives the router's PE input (send, data) and takes the router's PE output (send, data), returning ready.
- Injection is gated by the ring's global polarity (virtual-channel phase).

Parameters:
- WIDTH, 64, packet/data width; bit WIDTH-1 is the virtual-channel (VC) bit.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- polarity  input  1  ring phase, toggles each cycle; gates injection
- addr  input  2  register select: 0 = in_buf, 1 = in_status, 2 = out_buf, 3 = out_status
- d_in  input  WIDTH  processor write data
- d_out  output  WIDTH  processor read data (registered)
- nicEn  input  1  register access enable
- nicWrEn  input  1  1 = write, 0 = read (valid with nicEn)
- net_so  output  1  send to router PE input
- net_ro  input  1  router PE input ready
- net_do  output  WIDTH  packet to router PE input
- net_si  input  1  send from router PE output
- net_ri  output  1  ready to router PE output
- net_di  input  WIDTH  packet from router PE output

Behaviour:
- Reset (reset=0, asynchronous): in_buf, out_buf, d_out = 0; in_full, out_full = 0.
  - net_so=0, net_ri=1 immediately after reset deasserts.
- Input channel (network -> processor):
  - net_ri = !in_full, combinational from state.
  - Rising edge with net_si && net_ri: in_buf <= net_di, in_full <= 1.
  - net_si while net_ri=0: ignored. Router holds the packet; the NIC neither captures nor drops it.
- Output channel (processor -> network):
  - net_do = out_buf.
  - net_so = out_full && (out_buf[WIDTH-1] == polarity), combinational.
  - Rising edge with net_so && net_ro: out_full <= 0; out_buf retains its value.
  - out_full=1 with a VC mismatch: the packet waits, at most 1 cycle, since polarity toggles.
- Processor register access (sampled on rising edge when nicEn=1):
  - Read, nicWrEn=0: d_out <= selected value, 1-cycle latency.
    - addr0 -> in_buf.
    - addr1 -> {zeros, in_full} (bit0).
    - addr2 -> out_buf.
    - addr3 -> {zeros, out_full} (bit0).
  - Read of addr0 with in_full=1: in_full <= 0 on the same edge.
  - Read of addr0 with in_full=0: returns stale in_buf; no state change.
  - Write, nicWrEn=1, addr2, out_full=0: out_buf <= d_in, out_full <= 1.
  - Write to addr2 with out_full=1: dropped. out_buf and out_full unchanged, including on the same edge that a send completes (decision uses pre-edge out_full).
  - Writes to addr0/1/3: ignored.
  - nicEn=0: d_out holds its previous value.
- Simultaneous events:
  - Read addr0 clearing in_full while net_si asserted: no capture that edge, because net_ri was 0. Capture occurs the following edge if net_si is still high.
  - Input and output channels are independent. A processor write and a network receive on the same edge both take effect.
- Reset mid-transfer: full flags clear asynchronously and any pending packets are discarded. net_so drops immediately on reset assertion.
- Throughput: max one packet per direction per 2 cycles through the processor interface. The network side accepts/sends one packet per edge when the handshake allows.

Test Plan:
- Reset: hold reset=0 with net_si=1 and processor writes active. Release. -> net_so=0, net_ri=1; a read of addr1 then addr3 returns 0 and 0.
- Injection with polarity:
  - Write addr2 d_in=64'h8000_0000_0000_00AA with net_ro=1. -> out_full=1; net_so=1 only in cycles with polarity=1; net_do=64'h8000_0000_0000_00AA.
  - After the handshake edge, a read of addr3 returns 0.
- Backpressure:
  - net_ro=0 for 5 cycles after the write. -> net_so toggles with polarity and out_full stays 1.
  - Second write of 64'h1234 is dropped; out_buf still 64'h8000_0000_0000_00AA when net_ro rises.
- Reception:
  - net_si=1 with net_di=64'h0000_0000_0000_BEEF. -> net_ri falls after the edge; a read of addr1 returns 1.
  - A read of addr0 returns 64'hBEEF one cycle later; net_ri returns to 1 on that edge.
- Input full hold:
  - Second packet 64'hCAFE held on net_si while in_full=1. -> not captured until after the addr0 read; next edge captures 64'hCAFE.
- Async reset mid-operation:
  - Assert reset between clock edges with out_full=1 and in_full=1. -> net_so=0 and net_ri=1 immediately without a clock edge; a read of addr0 after release returns 0.
